// File: rtl/block_pe_elastic.sv
// block_pe_elastic: serially configured two-operand processing element that
// picks two of NUM_IN valid/ready input channels, applies a selectable ALU
// operation and buffers the results in a small elastic output FIFO.
// Optional feature macro: PE_ACCUM_EN (opcode 7 becomes accumulate ACC + A).
module block_pe_elastic #(
  parameter int WIDTH      = 32,
  parameter int NUM_IN     = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    config_en,
  input  logic                    config_in,
  output logic                    config_out,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int SELW = $clog2(NUM_IN);
  localparam int CFGL = 2 * SELW + 3;
  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam int CNTW = PTRW + 1;
  localparam int SHW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNTW-1:0] FULL_COUNT = CNTW'(FIFO_DEPTH);

  // Opcode 7 is PASS in the default build and ACC when PE_ACCUM_EN is defined.
  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_AND  = 3'd3,
    OP_OR   = 3'd4,
    OP_XOR  = 3'd5,
    OP_SHL  = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  logic [CFGL-1:0]  cfg;
  op_e              opcode;
  logic [SELW-1:0]  sel_a;
  logic [SELW-1:0]  sel_b;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] result;
  logic             operands_valid;
  logic             fire;
  logic             pop;
  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTRW-1:0]  wr_ptr;
  logic [PTRW-1:0]  rd_ptr;
  logic [CNTW-1:0]  count;
`ifdef PE_ACCUM_EN
  logic [WIDTH-1:0] acc_reg;
`endif

  assign opcode = op_e'(cfg[CFGL-1 -: 3]);
  assign sel_a  = cfg[2*SELW-1 -: SELW];
  assign sel_b  = cfg[SELW-1:0];
  assign opa    = in_data[int'(sel_a)*WIDTH +: WIDTH];
  assign opb    = in_data[int'(sel_b)*WIDTH +: WIDTH];
  assign shamt  = opb[SHW-1:0];

  assign config_out     = cfg[CFGL-1];
  assign operands_valid = in_valid[sel_a] & in_valid[sel_b];
  // Gating with reset keeps in_ready low while reset is held.
  assign fire      = reset & operands_valid & ~config_en &
                     ((count != FULL_COUNT) | out_ready);
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign out_data  = mem[rd_ptr];

  // Configuration shift chain, MSB exits on config_out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg <= '0;
    end else if (config_en) begin
      cfg <= {cfg[CFGL-2:0], config_in};
    end
  end

  // Handshake: only the selected channel(s) see ready, once per fire.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (fire && ((SELW'(i) == sel_a) || (SELW'(i) == sel_b))) begin
        in_ready[i] = 1'b1;
      end
    end
  end

  // ALU: every result is truncated to WIDTH bits.
  always_comb begin
    result = '0;
    case (opcode)
      OP_ADD:  result = opa + opb;
      OP_SUB:  result = opa - opb;
      OP_MUL:  result = opa * opb;
      OP_AND:  result = opa & opb;
      OP_OR:   result = opa | opb;
      OP_XOR:  result = opa ^ opb;
      OP_SHL:  result = opa << shamt;
`ifdef PE_ACCUM_EN
      OP_PASS: result = acc_reg + opa;
`else
      OP_PASS: result = opa;
`endif
      default: result = '0;
    endcase
  end

`ifdef PE_ACCUM_EN
  // Accumulator follows each ACC fire and is cleared whenever configuring.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_reg <= '0;
    end else if (config_en) begin
      acc_reg <= '0;
    end else if (fire && (opcode == OP_PASS)) begin
      acc_reg <= result;
    end
  end
`endif

  // FIFO pointers and occupancy; push and pop together leave count unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fire) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (fire && !pop) begin
        count <= count + 1'b1;
      end else if (!fire && pop) begin
        count <= count - 1'b1;
      end
    end
  end

  // FIFO storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (fire) begin
      mem[wr_ptr] <= result;
    end
  end

endmodule

// File: doc/block_pe_elastic.md
BLOCK_PE_ELASTIC -- requirements
Module: block_pe_elastic

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits.
REQ-002 Parameter NUM_IN, default 4, number of input channels (power of two, 2..16); SELW = log2(NUM_IN).
REQ-003 Parameter FIFO_DEPTH, default 2, output buffer entries (power of two, 2..8).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 config_en  input  1  high = configuration shift enabled; PE datapath stalled.
REQ-007 config_in  input  1  serial configuration bit in.
REQ-008 config_out  output  1  serial configuration bit out, to the next PE in the chain.
REQ-009 in_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-010 in_valid  input  NUM_IN  per-channel valid.
REQ-011 in_ready  output  NUM_IN  per-channel ready.
REQ-012 out_data  output  WIDTH  head entry of the output FIFO.
REQ-013 out_valid  output  1  output FIFO non-empty.
REQ-014 out_ready  input  1  downstream accepts out_data.

Function
REQ-015 Configuration register CFG is L = 2*SELW+3 bits: CFG[L-1:L-3] = opcode, CFG[2*SELW-1:SELW] = sel_a, CFG[SELW-1:0] = sel_b.
REQ-016 With config_en=1, each clk shifts CFG <= {CFG[L-2:0], config_in}; config_out = CFG[L-1] combinationally at all times.
REQ-017 Operands: A = channel sel_a, B = channel sel_b; operands_valid = in_valid[sel_a] & in_valid[sel_b].
REQ-018 fire = operands_valid & !config_en & (count < FIFO_DEPTH | out_ready).
REQ-019 in_ready[i] = fire & (i == sel_a | i == sel_b); unselected channels always 0; sel_a == sel_b consumes that channel once.
REQ-020 Opcodes: 0 ADD A+B, 1 SUB A-B, 2 MUL low WIDTH bits of A*B, 3 AND, 4 OR, 5 XOR, 6 SHL A << B[log2(WIDTH)-1:0], 7 PASS A; all results truncated modulo 2^WIDTH.
REQ-021 On fire the result is pushed into the FIFO at the clk edge; out_valid rises the next cycle (latency 1 cycle from fire to out_valid).
REQ-022 Pop occurs when out_valid & out_ready; FIFO is strict first-in first-out.
REQ-023 Simultaneous push and pop: count unchanged, including when full (count = FIFO_DEPTH) and when count = 1.
REQ-024 Full and out_ready=0: fire=0, all in_ready=0, FIFO contents held.
REQ-025 Read/write pointers wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.
REQ-026 config_en=1 blocks firing but does not block popping; buffered results drain normally.

Reset
REQ-027 reset low asynchronously clears CFG, FIFO pointers, count and accumulator to 0; out_valid=0, in_ready=0, config_out=0 while reset is low.
REQ-028 Reset mid-operation discards all buffered results; after release CFG = 0 (ADD, sel_a=sel_b=0).
REQ-029 Release is taken synchronously; the first fire is possible on the first clk edge after release.

Configuration
REQ-030 Macro PE_ACCUM_EN: when defined, opcode 7 is ACC: result = ACC_REG + A, ACC_REG <= result on fire; B is ignored but still consumed.
REQ-031 With PE_ACCUM_EN, ACC_REG clears on reset and on any cycle with config_en=1.
REQ-032 Without PE_ACCUM_EN, opcode 7 is PASS, no accumulator register exists, and L is unchanged.

Verification
REQ-033 Shift 2*SELW+3 bits selecting ADD, sel_a=1, sel_b=2; ch1=5, ch2=7 valid, out_ready=1 -> out_data=12 one cycle after fire, in_ready=4'b0110 in the fire cycle.
REQ-034 SUB with A=0, B=1 (WIDTH=32) -> out_data=32'hFFFFFFFF; MUL 32'h10000 * 32'h10000 -> 0.
REQ-035 out_ready=0, FIFO_DEPTH=2, three operand pairs offered -> two accepted, then in_ready=0; raise out_ready -> results emerge in order, third accepted on the pop cycle.
REQ-036 sel_a=sel_b=3, ch3=9 valid for one cycle, ADD -> single result 18, in_ready[3] pulses once.
REQ-037 PE_ACCUM_EN, ACC, A = 1,2,3 -> outputs 1,3,6; pulse config_en -> next A=4 yields 4.
REQ-038 Assert reset with FIFO holding 2 entries -> out_valid=0 immediately, CFG=0; config_out tracks CFG MSB after 1 shift.
